// File: rtl/apb_mem_slave_p.sv
// Parametrised APB memory slave with programmable wait states and PSLVERR on out-of-range words.
// Optional byte-strobe writes are enabled by defining APB_PSTRB_EN.
module apb_mem_slave_p #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [ADDR_W-1:0]   PADDR,
   input  logic [DATA_W-1:0]   PWDATA,
   input  logic [DATA_W/8-1:0] PSTRB,
   output logic [DATA_W-1:0]   PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      WS_C    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t              state, state_n;
   logic [3:0]          cnt, cnt_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic                write_q, write_n;
   logic                err_q, err_n;
   logic [DATA_W-1:0]   prdata_n;
   logic                mem_we;
   logic [DATA_W-1:0]   wr_mask;
   logic [DATA_W-1:0]   mem [DEPTH];

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      addr_n   = addr_q;
      write_n  = write_q;
      err_n    = err_q;
      prdata_n = PRDATA;
      mem_we   = 1'b0;
      unique case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               addr_n  = PADDR;
               write_n = PWRITE;
               err_n   = ({1'b0, PADDR} >= DEPTH_C);
               if (WS_C == 4'd0) begin
                  state_n = DONE;
               end else begin
                  state_n = WAIT;
                  cnt_n   = WS_C;
               end
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - 4'd1;
               if (cnt == 4'd1) state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
            mem_we  = PSEL && PENABLE && write_q && !err_q;
         end
         default: state_n = IDLE;
      endcase
      // addr_n/err_n cover both the zero-wait case (setup values) and the latched ones
      if (state_n == DONE && !write_n)
         prdata_n = err_n ? '0 : mem[addr_n[IDX_W-1:0]];
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         addr_q  <= addr_n;
         write_q <= write_n;
         err_q   <= err_n;
         PRDATA  <= prdata_n;
         PREADY  <= (state_n == DONE);
         PSLVERR <= (state_n == DONE) && err_n;
      end
   end

`ifdef APB_PSTRB_EN
   always_comb begin
      wr_mask = '0;
      for (int unsigned b = 0; b < DATA_W/8; b++)
         wr_mask[8*b +: 8] = {8{PSTRB[b]}};
   end
`else
   logic unused_strb;
   assign unused_strb = ^PSTRB;
   always_comb wr_mask = '1;
`endif

   always_ff @(posedge PCLK) begin
      if (mem_we && !PRESET)
         mem[addr_q[IDX_W-1:0]] <= (mem[addr_q[IDX_W-1:0]] & ~wr_mask) | (PWDATA & wr_mask);
   end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p: two slaves (0 and 2 wait states) on one APB bus, checked
// against an array-based memory model with random and directed transfers.
module tb_apb_mem_slave_p;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int DEPTH = 64;
   localparam int SW = DW/8;
   localparam int WS0 = 0;
   localparam int WS1 = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    psel;
   logic          penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [DW-1:0] prdata [2];
   logic          pready [2];
   logic          pslverr [2];

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem_m [2][DEPTH];
   logic [DW-1:0] prd_m [2];

   always #5 clk = ~clk;

   apb_mem_slave_p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_mem_slave_p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   function automatic int exp_ws(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   // Reference: word memory per slave, error for words at or beyond DEPTH, PRDATA holds between reads.
   task automatic model_xfer(input int d, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [SW-1:0] st,
                             output logic [DW-1:0] erd, output logic eer);
      logic en;
      eer = (int'(a) >= DEPTH);
      if (wr) begin
         if (!eer) begin
            for (int b = 0; b < SW; b++) begin
               en = 1'b1;
`ifdef APB_PSTRB_EN
               en = st[b];
`endif
               if (en) mem_m[d][a][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end else begin
         prd_m[d] = eer ? '0 : mem_m[d][a];
      end
      erd = prd_m[d];
   endtask

   // Called at posedge+1; returns at posedge+1 one cycle after PREADY was seen, bus idle.
   task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       output logic [DW-1:0] rd, output logic er, output int waits);
      psel = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = a;
      pwdata = wd;
      pstrb = st;
      @(posedge clk); #1;
      penable = 1'b1;
      paddr = AW'($urandom);
      pwrite = 1'($urandom_range(0, 1));
      waits = 0;
      while (pready[d] !== 1'b1 && waits < 40) begin
         @(posedge clk); #1;
         waits++;
      end
      rd = prdata[d];
      er = pslverr[d];
      @(posedge clk); #1;
      psel = '0;
      penable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (pready[d] !== 1'b0) begin errors++; $display("FAIL reset_pready dut%0d got %b exp 0", d, pready[d]); end
         checks++;
         if (pslverr[d] !== 1'b0) begin errors++; $display("FAIL reset_pslverr dut%0d got %b exp 0", d, pslverr[d]); end
         checks++;
         if (prdata[d] !== '0) begin errors++; $display("FAIL reset_prdata dut%0d got %h exp 0", d, prdata[d]); end
         prd_m[d] = '0;
      end
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [DW-1:0] rd, erd, wd;
      logic er, eer;
      int w;
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < DEPTH; a++) begin
            wd = $urandom;
            xfer(d, 1'b1, AW'(a), wd, '1, rd, er, w);
            model_xfer(d, 1'b1, AW'(a), wd, '1, erd, eer);
         end
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] rd, erd;
      logic er, eer;
      int w;
      xfer(0, 1'b1, 8'd3, 32'hA5, '1, rd, er, w);
      model_xfer(0, 1'b1, 8'd3, 32'hA5, '1, erd, eer);
      checks++;
      if (w !== 0) begin errors++; $display("FAIL basic_wr_waits got %0d exp 0", w); end
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b exp 0", er); end
      xfer(0, 1'b0, 8'd3, 32'h0, '1, rd, er, w);
      model_xfer(0, 1'b0, 8'd3, 32'h0, '1, erd, eer);
      checks++;
      if (rd !== 32'hA5) begin errors++; $display("FAIL basic_rd_data got %h exp 000000a5", rd); end
      checks++;
      if (w !== 0 || er !== 1'b0) begin errors++; $display("FAIL basic_rd_resp got waits=%0d err=%b exp 0/0", w, er); end
   endtask

   task automatic test_wait_states();
      logic [DW-1:0] rd, erd;
      logic er, eer;
      int w;
      xfer(1, 1'b1, 8'd3, 32'hA5, '1, rd, er, w);
      model_xfer(1, 1'b1, 8'd3, 32'hA5, '1, erd, eer);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL ws_wr_waits got %0d exp 2", w); end
      xfer(1, 1'b0, 8'd3, 32'h0, '1, rd, er, w);
      model_xfer(1, 1'b0, 8'd3, 32'h0, '1, erd, eer);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL ws_rd_waits got %0d exp 2", w); end
      checks++;
      if (rd !== 32'hA5 || er !== 1'b0) begin errors++; $display("FAIL ws_rd_data got %h err=%b exp 000000a5 err=0", rd, er); end
   endtask

   task automatic test_error();
      logic [DW-1:0] rd, erd;
      logic er, eer;
      int w;
      xfer(0, 1'b1, 8'd64, 32'h11, '1, rd, er, w);
      model_xfer(0, 1'b1, 8'd64, 32'h11, '1, erd, eer);
      checks++;
      if (er !== 1'b1 || w !== 0) begin errors++; $display("FAIL err_wr got err=%b waits=%0d exp 1/0", er, w); end
      xfer(0, 1'b0, 8'd64, 32'h0, '1, rd, er, w);
      model_xfer(0, 1'b0, 8'd64, 32'h0, '1, erd, eer);
      checks++;
      if (er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL err_rd got err=%b data=%h exp 1/0", er, rd); end
      checks++;
      if (pslverr[0] !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", pslverr[0]); end
      xfer(0, 1'b0, 8'd0, 32'h0, '1, rd, er, w);
      model_xfer(0, 1'b0, 8'd0, 32'h0, '1, erd, eer);
      checks++;
      if (rd !== erd || er !== 1'b0) begin errors++; $display("FAIL err_addr0 got %h err=%b exp %h err=0", rd, er, erd); end
      xfer(1, 1'b0, 8'd255, 32'h0, '1, rd, er, w);
      model_xfer(1, 1'b0, 8'd255, 32'h0, '1, erd, eer);
      checks++;
      if (er !== 1'b1 || rd !== '0 || w !== 2) begin errors++; $display("FAIL err_top got err=%b data=%h waits=%0d exp 1/0/2", er, rd, w); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rd, erd;
      logic er, eer;
      int w;
      xfer(0, 1'b1, 8'd5, 32'h3C, '1, rd, er, w);
      model_xfer(0, 1'b1, 8'd5, 32'h3C, '1, erd, eer);
      xfer(0, 1'b0, 8'd5, 32'h0, '1, rd, er, w);
      model_xfer(0, 1'b0, 8'd5, 32'h0, '1, erd, eer);
      checks++;
      if (rd !== 32'h3C || w !== 0) begin errors++; $display("FAIL b2b_rd got %h waits=%0d exp 0000003c/0", rd, w); end
   endtask

   task automatic test_abandon();
      logic [DW-1:0] rd, erd, prior;
      logic er, eer;
      int w;
      prior = mem_m[1][9];
      psel = 2'b10; pwrite = 1'b1; paddr = 8'd9; pwdata = ~prior; pstrb = '1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = '0; penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pready[1] !== 1'b0) begin errors++; $display("FAIL abandon_pready cyc%0d got %b exp 0", i, pready[1]); end
      end
      xfer(1, 1'b0, 8'd9, 32'h0, '1, rd, er, w);
      model_xfer(1, 1'b0, 8'd9, 32'h0, '1, erd, eer);
      checks++;
      if (rd !== prior) begin errors++; $display("FAIL abandon_mem got %h exp %h", rd, prior); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd, erd, prior;
      logic er, eer;
      int w;
      prior = mem_m[1][7];
      psel = 2'b10; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'hFF; pstrb = '1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      prd_m[0] = '0;
      prd_m[1] = '0;
      checks++;
      if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0) begin errors++; $display("FAIL rstmid_resp got rdy=%b err=%b exp 0/0", pready[1], pslverr[1]); end
      checks++;
      if (prdata[1] !== '0) begin errors++; $display("FAIL rstmid_prdata got %h exp 0", prdata[1]); end
      // PSEL and PENABLE stay high in IDLE: no setup phase, so nothing may start
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (pready[1] !== 1'b0) begin errors++; $display("FAIL idle_penable cyc%0d got %b exp 0", i, pready[1]); end
      end
      psel = '0; penable = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1'b0, 8'd7, 32'h0, '1, rd, er, w);
      model_xfer(1, 1'b0, 8'd7, 32'h0, '1, erd, eer);
      checks++;
      if (rd !== prior) begin errors++; $display("FAIL rstmid_mem got %h exp %h", rd, prior); end
   endtask

   task automatic test_pstrb();
      logic [DW-1:0] rd, erd, exp;
      logic er, eer;
      int w;
`ifdef APB_PSTRB_EN
      exp = 32'h11BB33DD;
`else
      exp = 32'hAABBCCDD;
`endif
      xfer(0, 1'b1, 8'd2, 32'h11223344, 4'hF, rd, er, w);
      model_xfer(0, 1'b1, 8'd2, 32'h11223344, 4'hF, erd, eer);
      xfer(0, 1'b1, 8'd2, 32'hAABBCCDD, 4'b0101, rd, er, w);
      model_xfer(0, 1'b1, 8'd2, 32'hAABBCCDD, 4'b0101, erd, eer);
      xfer(0, 1'b0, 8'd2, 32'h0, 4'h0, rd, er, w);
      model_xfer(0, 1'b0, 8'd2, 32'h0, 4'h0, erd, eer);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL pstrb_merge got %h exp %h", rd, exp); end
      xfer(0, 1'b1, 8'd2, 32'h5A5A5A5A, 4'h0, rd, er, w);
      model_xfer(0, 1'b1, 8'd2, 32'h5A5A5A5A, 4'h0, erd, eer);
      checks++;
      if (w !== 0 || er !== 1'b0) begin errors++; $display("FAIL pstrb_zero_resp got waits=%0d err=%b exp 0/0", w, er); end
      xfer(0, 1'b0, 8'd2, 32'h0, 4'h0, rd, er, w);
      model_xfer(0, 1'b0, 8'd2, 32'h0, 4'h0, erd, eer);
      checks++;
      if (rd !== erd) begin errors++; $display("FAIL pstrb_zero_mem got %h exp %h", rd, erd); end
   endtask

   task automatic test_random();
      logic [DW-1:0] rd, erd, wd;
      logic er, eer, wr;
      logic [AW-1:0] a;
      logic [SW-1:0] st;
      int w, d;
      for (int i = 0; i < 300; i++) begin
         d  = $urandom_range(0, 1);
         wr = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, DEPTH + 7));
         wd = $urandom;
         st = SW'($urandom);
         xfer(d, wr, a, wd, st, rd, er, w);
         model_xfer(d, wr, a, wd, st, erd, eer);
         checks++;
         if (rd !== erd || er !== eer || w !== exp_ws(d)) begin
            errors++;
            $display("FAIL rand%0d dut%0d wr=%b a=%0d got %h/%b/%0d exp %h/%b/%0d", i, d, wr, a, rd, er, w, erd, eer, exp_ws(d));
         end
         checks++;
         if (pready[d] !== 1'b0) begin errors++; $display("FAIL rand%0d_done_exit got %b exp 0", i, pready[d]); end
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      psel = '0;
      penable = 1'b0;
      pwrite = 1'b0;
      paddr = '0;
      pwdata = '0;
      pstrb = '0;
      test_reset();
      test_fill();
      test_basic();
      test_wait_states();
      test_error();
      test_back_to_back();
      test_abandon();
      test_reset_mid();
      test_pstrb();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
Parametrised APB memory-mapped slave: the next generation of the team's fixed 8-bit/64-entry APB slaves. Adds configurable data/address width and depth, programmable wait states, registered PREADY/PRDATA, and PSLVERR for out-of-range accesses. Sits behind the APB master/decoder, one instance per PSELx.

Parameters:
DATA_W, 8, width of PWDATA/PRDATA in bits (multiple of 8)
ADDR_W, 8, width of PADDR in bits; PADDR is a word index
DEPTH, 64, number of memory words; must be ≤ 2**ADDR_W
WAIT_STATES, 0, extra access-phase cycles before PREADY (0..15)

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  reset
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  word address
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  byte strobes (used only with APB_PSTRB_EN)
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Interface: one clock; reset is synchronous and active-high. PRESET sampled on PCLK rising edge.
- Reset values: state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0. Memory contents not reset.
- FSM states IDLE, WAIT, DONE. PREADY = (state==DONE), registered.
- IDLE: PSEL=1 & PENABLE=0 (setup) → latch PADDR, PWRITE, err = (PADDR ≥ DEPTH). Next state DONE if WAIT_STATES=0, else WAIT with cnt=WAIT_STATES.
- WAIT: cnt decrements each cycle; at cnt==1 → DONE. PSEL=0 → IDLE, transfer abandoned, no memory effect.
- Access phase therefore lasts exactly WAIT_STATES+1 cycles; PREADY high only in the last one.
- Read: PRDATA loaded on the edge entering DONE with mem[latched addr], or 0 if err. PRDATA holds its value otherwise.
- Write: on the DONE edge with PSEL&PENABLE&PWRITE, mem[latched addr] ← PWDATA. Skipped if err; memory unchanged.
- PSLVERR = DONE & err; cleared on leaving DONE.
- DONE → IDLE unconditionally. A back-to-back setup phase in the following cycle is accepted normally, so there is no dead cycle beyond APB's own.
- Address/direction come from the latched setup-phase values. Changes to PADDR/PWRITE during access phase are ignored. PWDATA is sampled on the DONE edge.
- PENABLE=1 while in IDLE (protocol violation): ignored, stays IDLE, PREADY=0.
- PRESET mid-transfer: immediate return to IDLE, PREADY/PSLVERR=0 next cycle, pending write not performed.

Optional Feature:
APB_PSTRB_EN
- Defined: write updates only bytes whose PSTRB bit is 1. PSTRB=0 completes normally (PREADY, no error) with memory unchanged.
- Undefined: PSTRB is ignored and every write updates the full word.

Test Plan:
- WAIT_STATES=0: write 0xA5 to addr 3, then read addr 3 → PREADY in first access cycle each time, PRDATA=0xA5, PSLVERR=0.
- WAIT_STATES=2: read addr 3 → PREADY low for 2 access cycles and high on the 3rd, PRDATA=0xA5.
- DEPTH=64: write 0x11 to addr 64, then read addr 64 → PSLVERR=1 with PREADY, PRDATA=0. Readback of addr 0 is unchanged.
- Back-to-back transfers: write addr 5=0x3C, next cycle setup read addr 5 → PRDATA=0x3C, no extra idle cycle.
- PRESET asserted in WAIT during a write of 0xFF to addr 7 → PREADY=0 next cycle, mem[7] retains its prior value.
- APB_PSTRB_EN, DATA_W=32: mem[2]=0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 → read returns 0x11BB33DD.
